router_fsm: RTL

Control state machine for the 1x3 router input path. It decodes the header address, sequences the register block through load/full/parity phases via one-hot phase strobes, gates FIFO writes, and raises busy to stall the source. It sits between the source interface, the register block, the three output FIFOs and the synchronizer (which supplies fifo_full, fifo_empty_n and soft_reset_n).

---
 rtl/router_fsm_if.sv | 39 +++
 rtl/router_fsm.sv | 126 ++++++++++++
 2 files changed

// File: rtl/router_fsm_if.sv
// Signal bundle between the router control FSM and the source, register block
// and synchronizer. The FSM uses the slave side.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] din;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       busy;
  logic       detect_addr;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       write_enb_reg;

  modport slave (
    input  pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    output busy, detect_addr, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg
  );

  modport master (
    output pkt_valid, din, parity_done, low_pkt_valid, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
    input  busy, detect_addr, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg
  );
endinterface

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router input path: header decode, load/full/parity
// phase sequencing, FIFO write gating and source stall.
module router_fsm (
  input  logic        clk,
  input  logic        rst,
  router_fsm_if.slave bus
);
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned PORT_CNT = 3;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PORT_CNT-1:0] fifo_empty_v;
  logic [PORT_CNT-1:0] soft_reset_v;
  logic                hdr_ok;
  logic                empty_din;
  logic                empty_addr;
  logic                soft_sel;

  // Per-port select; the reserved address maps to 0.
  function automatic logic port_bit(input logic [PORT_CNT-1:0] v,
                                    input logic [ADDR_W-1:0]   a);
    case (a)
      2'd0:    port_bit = v[0];
      2'd1:    port_bit = v[1];
      2'd2:    port_bit = v[2];
      default: port_bit = 1'b0;
    endcase
  endfunction

  assign fifo_empty_v = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_reset_v = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
  assign hdr_ok       = bus.pkt_valid && (bus.din != ADDR_INVALID);
  assign empty_din    = port_bit(fifo_empty_v, bus.din);
  assign empty_addr   = port_bit(fifo_empty_v, addr_q);
  assign soft_sel     = port_bit(soft_reset_v, addr_q);

  // State and latched destination address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state, address capture and Moore output decode.
  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    bus.busy          = 1'b0;
    bus.detect_addr   = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.write_enb_reg = 1'b0;

    case (state_q)
      DECODE_ADDRESS: begin
        bus.detect_addr = 1'b1;
        if (hdr_ok) begin
          addr_d  = bus.din;
          state_d = empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: begin
        bus.busy      = 1'b1;
        bus.lfd_state = 1'b1;
        state_d       = LOAD_DATA;
      end
      LOAD_DATA: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        bus.busy       = 1'b1;
        bus.full_state = 1'b1;
        if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        bus.busy          = 1'b1;
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      LOAD_PARITY: begin
        bus.busy          = 1'b1;
        bus.write_enb_reg = 1'b1;
        state_d           = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        bus.busy        = 1'b1;
        bus.rst_int_reg = 1'b1;
        state_d         = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        bus.busy = 1'b1;
        if (empty_addr) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A read timeout on the selected port aborts the packet from any state.
    if ((state_q != DECODE_ADDRESS) && soft_sel) state_d = DECODE_ADDRESS;
  end
endmodule
